// File: rtl/ifetch_pair_buffer_pkg.sv
// Shared SPU definitions for fetch and decode: local-store address width,
// instruction word width, instruction formats and the fetched-pair entry layout.
package ifetch_pair_buffer_pkg;

  localparam int unsigned LS_ADDR_W = 18;
  localparam int unsigned INSTR_W   = 32;

  typedef enum logic [2:0] {
    RRR  = 3'd0,
    RR   = 3'd1,
    RI7  = 3'd2,
    RI10 = 3'd3,
    RI16 = 3'd4,
    RI18 = 3'd5
  } instr_fmt_t;

  typedef struct packed {
    logic [0:INSTR_W-1]   instr1;
    logic [0:INSTR_W-1]   instr2;
    logic [0:LS_ADDR_W-1] pc;
    logic                 v1;
    logic                 v2;
  } pair_entry_t;

  function automatic logic [0:LS_ADDR_W-1] pair_align(input logic [0:LS_ADDR_W-1] addr);
    return {addr[0:LS_ADDR_W-4], 3'b000};
  endfunction

endpackage

// File: rtl/ifetch_pair_fifo.sv
// In-order FIFO of fetched instruction pairs with a head-v1 clear port and
// synchronous flush; flush and reset both empty it.
module ifetch_pair_fifo
  import ifetch_pair_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  pair_entry_t           push_data,
  input  logic                  pop,
  input  logic                  clr_v1,
  output pair_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  pair_entry_t   mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;

  // Entry storage; a clear of head v1 never targets the slot being written.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_r[wr_ptr_r] <= push_data;
    end
    if (clr_v1 && !pop && !flush && !rst) begin
      mem_r[rd_ptr_r].v1 <= 1'b0;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/ifetch_pair_buffer.sv
// Dual-issue SPU fetch front end: aligned pair requests, credit/discard tracking
// and head-pair presentation. Optional counters under IFB_PERF_CNT_EN.
module ifetch_pair_buffer
  import ifetch_pair_buffer_pkg::*;
#(
  parameter int unsigned          DEPTH           = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter int unsigned          LS_ADDR_W       = ifetch_pair_buffer_pkg::LS_ADDR_W,
  parameter logic [0:LS_ADDR_W-1] RESET_PC        = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ls_req,
  output logic [0:LS_ADDR_W-1] ls_addr,
  input  logic                 ls_gnt,
  input  logic                 ls_rvalid,
  input  logic [0:63]          ls_rdata,
  output logic [0:31]          instruction_out1,
  output logic [0:31]          instruction_out2,
  output logic                 valid_out1,
  output logic                 valid_out2,
  output logic [0:LS_ADDR_W-1] pc_out,
  input  logic                 stall_in,
  input  logic                 single_in,
  input  logic                 flush_in,
  input  logic [0:LS_ADDR_W-1] flush_pc_in
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [0:31]          bubble_cnt,
  output logic [0:31]          flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING + 1);

  pair_entry_t          head_s;
  pair_entry_t          push_data_s;
  logic [CW-1:0]        count_s;
  logic [0:LS_ADDR_W-1] fetch_pc_r;
  logic [0:LS_ADDR_W-1] resp_pc_r;
  logic [PW-1:0]        pending_r;
  logic [PW-1:0]        discard_r;
  logic [PW-1:0]        pending_next_s;
  logic                 odd_start_r;
  logic                 empty_s;
  logic                 req_s;
  logic                 fire_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 clr_v1_s;
  logic [31:0]          occupancy_s;

  ifetch_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_in),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .clr_v1    (clr_v1_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Requests only when a FIFO slot is reserved for every live (non-discarded) request.
  always_comb begin
    empty_s        = (count_s == '0);
    occupancy_s    = 32'(count_s) + 32'(pending_r) - 32'(discard_r);
    req_s          = !rst && !flush_in && (32'(pending_r) < 32'(MAX_OUTSTANDING))
                     && (occupancy_s < 32'(DEPTH));
    fire_s         = req_s && ls_gnt;
    pending_next_s = pending_r + PW'(fire_s) - PW'(ls_rvalid);
    push_s         = 1'b0;
    pop_s          = 1'b0;
    clr_v1_s       = 1'b0;
    if (flush_in) begin
      push_s = 1'b0;
    end else begin
      push_s = ls_rvalid && (discard_r == '0);
      if (!stall_in && !empty_s) begin
        if (single_in && head_s.v1 && head_s.v2) begin
          clr_v1_s = 1'b1;
        end else begin
          pop_s = 1'b1;
        end
      end else begin
        pop_s = 1'b0;
      end
    end
    push_data_s = '{instr1: ls_rdata[0:31], instr2: ls_rdata[32:63], pc: resp_pc_r,
                    v1: !odd_start_r, v2: 1'b1};
  end

  // Fetch address, credit and discard bookkeeping; resp_pc tracks the next live response.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r  <= RESET_PC;
      resp_pc_r   <= RESET_PC;
      pending_r   <= '0;
      discard_r   <= '0;
      odd_start_r <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      if (flush_in) begin
        discard_r   <= pending_next_s;
        fetch_pc_r  <= pair_align(flush_pc_in);
        resp_pc_r   <= pair_align(flush_pc_in);
        odd_start_r <= flush_pc_in[LS_ADDR_W-3];
      end else begin
        if (fire_s) begin
          fetch_pc_r <= fetch_pc_r + LS_ADDR_W'(8);
        end
        if (ls_rvalid) begin
          if (discard_r != '0) begin
            discard_r <= discard_r - PW'(1);
          end else begin
            resp_pc_r   <= resp_pc_r + LS_ADDR_W'(8);
            odd_start_r <= 1'b0;
          end
        end
      end
    end
  end

  assign ls_req           = req_s;
  assign ls_addr          = fetch_pc_r;
  assign instruction_out1 = empty_s ? 32'h0 : head_s.instr1;
  assign instruction_out2 = empty_s ? 32'h0 : head_s.instr2;
  assign valid_out1       = empty_s ? 1'b0 : head_s.v1;
  assign valid_out2       = empty_s ? 1'b0 : head_s.v2;
  assign pc_out           = empty_s ? '0 : head_s.pc;

`ifdef IFB_PERF_CNT_EN
  // Saturating bubble and flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= 32'h0;
      flush_cnt  <= 32'h0;
    end else begin
      if (empty_s && !flush_in && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (flush_in && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_pair_buffer.sv
// Bench for ifetch_pair_buffer: queue-based reference model, local-store model
// with programmable latency, and directed scenarios with literal expectations.
module tb_ifetch_pair_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int AW    = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          ls_req;
  logic [0:AW-1] ls_addr;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [0:63]   ls_rdata;
  logic [0:31]   instruction_out1;
  logic [0:31]   instruction_out2;
  logic          valid_out1;
  logic          valid_out2;
  logic [0:AW-1] pc_out;
  logic          stall_in;
  logic          single_in;
  logic          flush_in;
  logic [0:AW-1] flush_pc_in;
`ifdef IFB_PERF_CNT_EN
  logic [0:31]   bubble_cnt;
  logic [0:31]   flush_cnt;
`endif

  ifetch_pair_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .LS_ADDR_W(AW), .RESET_PC(18'h0)) dut (
    .clk(clk), .rst(rst), .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .instruction_out1(instruction_out1),
    .instruction_out2(instruction_out2), .valid_out1(valid_out1), .valid_out2(valid_out2),
    .pc_out(pc_out), .stall_in(stall_in), .single_in(single_in), .flush_in(flush_in),
    .flush_pc_in(flush_pc_in)
`ifdef IFB_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned pc; bit v1; bit v2; } ment_t;
  typedef struct { int unsigned addr; int due; } mreq_t;
  typedef struct { int unsigned pc; bit v1; bit v2; logic [0:31] i1; logic [0:31] i2; } obs_t;

  ment_t       mq[$];
  mreq_t       memq[$];
  obs_t        used_log[$];
  int unsigned fire_log[$];
  int unsigned m_pend, m_disc, m_fpc, m_bub, m_fl;
  bit          m_odd;
  int          cyc, lat;
  int          checks, errors;
  bit          rv;
  int unsigned rv_addr;

  function automatic logic [31:0] word(input int unsigned a);
    return 32'h4000_0000 + (a << 19);
  endfunction

  function automatic int unsigned fire_at(input int i);
    return (i < fire_log.size()) ? fire_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic obs_t used_at(input int i);
    obs_t o;
    o = '{32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0};
    if (i < used_log.size()) o = used_log[i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_req();
    return !flush_in && (m_pend < MAXO) && ((32'(mq.size()) + m_pend - m_disc) < 32'(DEPTH));
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    chk("ls_req", 64'(ls_req), 64'(model_req()));
    chk("ls_addr", 64'(ls_addr), 64'(m_fpc));
    if (mq.size() == 0) begin
      chk("valid_out1_empty", 64'(valid_out1), 64'd0);
      chk("valid_out2_empty", 64'(valid_out2), 64'd0);
      chk("pc_out_empty", 64'(pc_out), 64'd0);
      chk("instr1_empty", 64'(instruction_out1), 64'd0);
      chk("instr2_empty", 64'(instruction_out2), 64'd0);
    end else begin
      chk("valid_out1", 64'(valid_out1), 64'(mq[0].v1));
      chk("valid_out2", 64'(valid_out2), 64'(mq[0].v2));
      chk("pc_out", 64'(pc_out), 64'(mq[0].pc));
      chk("instr1", 64'(instruction_out1), 64'(word(mq[0].pc)));
      chk("instr2", 64'(instruction_out2), 64'(word(mq[0].pc + 32'd4)));
    end
`ifdef IFB_PERF_CNT_EN
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_fl));
`endif
  endtask

  // One clock: drive memory response, compare, advance model, clock.
  task automatic step();
    bit    fire;
    ment_t e;
    rv = 1'b0; ls_rvalid = 1'b0; ls_rdata = '0;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
      rv = 1'b1; rv_addr = memq[0].addr;
      ls_rvalid = 1'b1;
      ls_rdata = {word(rv_addr), word(rv_addr + 32'd4)};
    end
    #1;
    if (rst) begin
      @(posedge clk);
      mq.delete(); memq.delete();
      m_pend = 0; m_disc = 0; m_fpc = 0; m_odd = 1'b0; m_bub = 0; m_fl = 0;
    end else begin
      compare();
      if (ls_req === 1'b1 && ls_gnt === 1'b1) fire_log.push_back(32'(ls_addr));
      if (!flush_in && !stall_in && (valid_out1 === 1'b1 || valid_out2 === 1'b1))
        used_log.push_back('{32'(pc_out), valid_out1, valid_out2, instruction_out1, instruction_out2});
      fire = model_req() && ls_gnt;
      if (mq.size() == 0 && !flush_in && m_bub != 32'hFFFF_FFFF) m_bub++;
      if (fire) memq.push_back('{m_fpc, cyc + lat});
      if (flush_in) begin
        mq.delete();
        if (rv) m_pend--;
        m_disc = m_pend;
        m_fpc  = 32'(flush_pc_in) & 32'h3FFF8;
        m_odd  = (32'(flush_pc_in) & 32'h4) != 0;
        if (m_fl != 32'hFFFF_FFFF) m_fl++;
      end else begin
        if (!stall_in && mq.size() > 0) begin
          if (single_in && mq[0].v1 && mq[0].v2) begin
            e = mq[0]; e.v1 = 1'b0; mq[0] = e;
          end else begin
            void'(mq.pop_front());
          end
        end
        if (rv) begin
          m_pend--;
          if (m_disc > 0) m_disc--;
          else begin
            mq.push_back('{rv_addr, !m_odd, 1'b1});
            m_odd = 1'b0;
          end
        end
        if (fire) begin
          m_pend++;
          m_fpc = (m_fpc + 32'd8) & 32'h3FFFF;
        end
      end
      if (rv) void'(memq.pop_front());
      @(posedge clk);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_in = 1'b0; stall_in = 1'b0; single_in = 1'b0; ls_gnt = 1'b1;
    step();
    chk("rst_req", 64'(ls_req), 64'd0);
    chk("rst_valid", 64'({valid_out1, valid_out2}), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'd0);
    step();
    rst = 1'b0;
    fire_log.delete(); used_log.delete();
  endtask

  obs_t u;
  int   bad;

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 2;
    rst = 1'b1; stall_in = 1'b0; single_in = 1'b0; flush_in = 1'b0;
    flush_pc_in = '0; ls_gnt = 1'b0; ls_rvalid = 1'b0; ls_rdata = '0;
    @(negedge clk);

    // Streaming, 2-cycle memory, no stall.
    lat = 2; do_reset();
    chk("t1_ls_addr_first", 64'(ls_addr), 64'd0);
    run(8);
    chk("t1_addr0", 64'(fire_at(0)), 64'h0);
    chk("t1_addr1", 64'(fire_at(1)), 64'h8);
    chk("t1_addr2", 64'(fire_at(2)), 64'h10);
    u = used_at(0);
    chk("t1_pc", 64'(u.pc), 64'h0);
    chk("t1_valid", 64'({u.v1, u.v2}), 64'h3);
    chk("t1_i1", 64'(u.i1), 64'h4000_0000);
    chk("t1_i2", 64'(u.i2), 64'h4020_0000);

    // Fill under stall, then drain in order.
    do_reset(); stall_in = 1'b1;
    run(10);
    chk("t2_fires", 64'(fire_log.size()), 64'd4);
    chk("t2_req_full", 64'(ls_req), 64'd0);
    stall_in = 1'b0;
    run(4);
    for (int i = 0; i < 4; i++) chk("t2_order", 64'(used_at(i).pc), 64'(i * 8));

    // Single-slot issue on head 0x20.
    stall_in = 1'b1; run(3);
    chk("t3_head", 64'(pc_out), 64'h20);
    stall_in = 1'b0; single_in = 1'b1; step();
    stall_in = 1'b1; single_in = 1'b0;
    chk("t3_valid01", 64'({valid_out1, valid_out2}), 64'h1);
    chk("t3_same_pc", 64'(pc_out), 64'h20);
    chk("t3_instr2", 64'(instruction_out2), 64'h4120_0000);
    stall_in = 1'b0; single_in = 1'b1; step();
    stall_in = 1'b1; single_in = 1'b0;
    chk("t3_next_pc", 64'(pc_out), 64'h28);
    chk("t3_next_valid", 64'({valid_out1, valid_out2}), 64'h3);

    // Flush to an odd word with two requests pending.
    lat = 4; do_reset(); stall_in = 1'b1;
    run(2);
    fire_log.delete();
    flush_in = 1'b1; flush_pc_in = 18'h00104; step(); flush_in = 1'b0;
    run(12);
    chk("t4_addr", 64'(fire_at(0)), 64'h100);
    chk("t4_addr_next", 64'(fire_at(1)), 64'h108);
    chk("t4_pc", 64'(pc_out), 64'h100);
    chk("t4_valid01", 64'({valid_out1, valid_out2}), 64'h1);
    chk("t4_instr2", 64'(instruction_out2), 64'h4820_0000);

    // Flush coincident with a response and a granting memory.
    lat = 2; do_reset();
    run(2);
    flush_in = 1'b1; flush_pc_in = 18'h00200; step(); flush_in = 1'b0;
    chk("t5_empty", 64'({valid_out1, valid_out2}), 64'h0);
    used_log.delete();
    run(12);
    chk("t5_first_pc", 64'(used_at(0).pc), 64'h200);
    bad = 0;
    foreach (used_log[i]) if (used_log[i].pc < 32'h200) bad++;
    chk("t5_no_stale", 64'(bad), 64'd0);

    // Address wrap at the top of local store.
    do_reset(); stall_in = 1'b1;
    flush_in = 1'b1; flush_pc_in = 18'h3FFF8; step(); flush_in = 1'b0;
    run(8);
    chk("t6_addr_top", 64'(fire_at(0)), 64'h3FFF8);
    chk("t6_addr_wrap", 64'(fire_at(1)), 64'h0);
    chk("t6_head", 64'(pc_out), 64'h3FFF8);

    // Minimum latency: response visible the cycle after acceptance.
    lat = 1; do_reset(); stall_in = 1'b1;
    step();
    chk("t7_not_yet", 64'(valid_out1), 64'd0);
    step();
    chk("t7_visible", 64'({valid_out1, valid_out2}), 64'h3);

    // Mixed directed traffic: intermittent grant, stalls, single issue, flushes.
    lat = 3; do_reset();
    for (int i = 0; i < 40; i++) begin
      ls_gnt      = (i % 3 != 1);
      stall_in    = (i % 5 == 2) || (i >= 12 && i < 18);
      single_in   = (i % 4 == 1);
      flush_in    = (i == 20) || (i == 31);
      flush_pc_in = (i == 20) ? 18'h00ABC : 18'h001F0;
      step();
    end
    flush_in = 1'b0; stall_in = 1'b0; single_in = 1'b0; ls_gnt = 1'b1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_pair_buffer.md
Name: ifetch_pair_buffer

Overview:
- Instruction fetch front end for the dual-issue SPU.
- Issues aligned doubleword (two-instruction) fetches to local store and buffers the returned pairs in an in-order FIFO.
- Presents the head pair to the ID/hazard stage as instruction slot 1 (even word) and slot 2 (odd word).
- Honours stall, single-slot issue and branch flush from downstream.

Parameters:
- DEPTH, 4, FIFO entries (instruction pairs); power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum in-flight local-store requests.
- LS_ADDR_W, 18, local-store byte address width (256 KB).
- RESET_PC, 0, fetch byte address after reset (8-byte aligned).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ls_req  out  1  fetch request valid
- ls_addr  out  [0:LS_ADDR_W-1]  byte address; bits [LS_ADDR_W-3:LS_ADDR_W-1] are always 0
- ls_gnt  in  1  request accepted this cycle (fires when ls_req && ls_gnt)
- ls_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant
- ls_rdata  in  [0:63]  [0:31] = word at addr, [32:63] = word at addr+4
- instruction_out1  out  [0:31]  slot-1 (even-address) instruction
- instruction_out2  out  [0:31]  slot-2 (odd-address) instruction
- valid_out1  out  1  slot 1 holds an unissued instruction
- valid_out2  out  1  slot 2 holds an unissued instruction
- pc_out  out  [0:LS_ADDR_W-1]  byte address of the head pair (8-aligned)
- stall_in  in  1  ID/HU consumes nothing this cycle
- single_in  in  1  ID/HU consumes slot 1 only
- flush_in  in  1  redirect (branch taken or mispredict)
- flush_pc_in  in  [0:LS_ADDR_W-1]  redirect byte target (4-aligned)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On reset, FIFO empty, fetch_pc=RESET_PC, pending=0, discard=0, and all outputs 0.
- FIFO entry: {instr1, instr2, pc, v1, v2}.
- Outputs: driven combinationally from the head entry. With the FIFO empty, valid_out1/2=0 and instruction/pc outputs are 0.
- Write latency: a response accepted in cycle N is visible at the outputs in cycle N+1 if the FIFO was empty. No bypass.
- Request rule: ls_req=1 when !flush_in, pending<MAX_OUTSTANDING, and count+(pending-discard)<DEPTH. Space is therefore reserved for every live request, so there is no overflow and no backpressure on responses.
- On fire: pending+1, fetch_pc += 8, wrapping modulo 2^LS_ADDR_W. ls_addr stays stable while ls_req=1 and ls_gnt=0.
- Response: pending-1. If discard>0, decrement discard and drop the data. Otherwise push an entry with v1=v2=1, except that the first pair after a redirect to an odd word gets v1=0.
- Consume:
  - flush_in=0, stall_in=1: no change.
  - stall_in=0, single_in=0: pop the head (both slots consumed). Slots with v=0 are simply skipped.
  - stall_in=0, single_in=1, head v1=1 and v2=1: clear head v1 and do not pop. Next cycle shows valid_out1=0, valid_out2=1 for the same pc.
  - single_in with only one valid slot: treated as a full pop.
- Flush (highest priority; overrides stall, single, and any push):
  - Empty the FIFO.
  - discard := pending_next, counting a grant this cycle and excluding a response this cycle.
  - fetch_pc := flush_pc_in & ~7.
  - Set the odd-start flag from flush_pc_in bit [LS_ADDR_W-3].
  - ls_req=0 in the flush cycle; fetching resumes the next cycle even while discards drain.
- Push and pop in the same cycle: count unchanged. At count==DEPTH, no request is issued.
- Reset mid-transaction: in-flight responses after reset are undefined. The memory side is reset on the same rst.

Optional Feature:
- Macro IFB_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt [0:31] and flush_cnt [0:31].
  - bubble_cnt increments each cycle with the FIFO empty and !flush_in.
  - flush_cnt increments per flush_in cycle.
  - Both cleared by rst and saturating at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared SPU package: LS_ADDR_W, instruction word width (32), the pair-entry struct typedef, and the instruction-format localparams RRR/RR/RI7/RI10/RI16/RI18 (already shared with decode).
- One natural sub-module: ifetch_pair_fifo (DEPTH-entry, in-order, head-v1 clear port, synchronous flush). Request/credit/discard logic stays in the top.

Test Plan:
- Reset, then grant every cycle with 2-cycle memory latency and no stall: first ls_addr=0x00000, then 0x00008, 0x00010. First pair 0x40000000/0x40200000 appears with pc 0 and valid 11.
- stall_in held for 10 cycles, memory always ready: FIFO fills to DEPTH=4, ls_req drops with count+live pending=4. Release: pairs pc 0, 8, 10, 18 in order with no loss.
- single_in=1 on a head at pc 0x20: next cycle valid_out=01, same pc and instruction_out2. Then pop to pc 0x28.
- flush_in with flush_pc_in=0x00104 while 2 requests are pending: the 2 stale responses are dropped. Next ls_addr=0x00100, and the first pair shows valid 01, pc 0x00100.
- flush_in coincident with a response and a grant: both are discarded (discard=pending_next). The FIFO is empty the next cycle and no stale pc ever appears.
- fetch_pc=0x3FFF8: the next request address wraps to 0x00000.
- IFB_PERF_CNT_EN defined: 5 empty cycles give bubble_cnt=5; 3 flushes give flush_cnt=3.
